rx_packet_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares one AXI-Stream output (to the DMA/CPU sink)

---
 rtl/rx_arb_pkg.sv | 27 ++
 rtl/rr_priority_picker.sv | 30 +++
 rtl/rx_packet_arbiter.sv | 129 ++++++++++++
 tb/tb_rx_packet_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_arb_pkg.sv
// Shared types and helpers for the receive-side packet arbiter.
package rx_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_STREAM = 3'b010,
        ST_SETTLE = 3'b100
    } arb_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 1) ? value - 1 : 0;
        while (rem != 0) begin
            rem = rem >> 1;
            result++;
        end
        return result;
    endfunction

    // LSB offset of channel ch in a flattened bus of width-bit fields, ch0 in the LSBs.
    function automatic int unsigned field_lo(input int unsigned ch, input int unsigned width);
        return ch * width;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin pick: first requester scanning upward from last+1, with wrap.
module rr_priority_picker #(
    parameter int unsigned C_NUM_CH   = 2,
    parameter int unsigned C_ID_WIDTH = 3
) (
    input  logic [C_NUM_CH-1:0]   req,
    input  logic [C_ID_WIDTH-1:0] last,
    output logic                  valid,
    output logic [C_ID_WIDTH-1:0] idx
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        // Offset C_NUM_CH lands back on last itself, so it is considered last of all.
        for (int unsigned k = 1; k <= C_NUM_CH; k++) begin
            cand = (32'(last) + k) % C_NUM_CH;
            for (int unsigned c = 0; c < C_NUM_CH; c++) begin
                if (!valid && c == cand && req[c]) begin
                    valid = 1'b1;
                    idx   = C_ID_WIDTH'(c);
                end
            end
        end
    end

endmodule

// File: rtl/rx_packet_arbiter.sv
// Packet-granular round-robin arbiter merging N receive channels onto one AXI-Stream sink.
module rx_packet_arbiter
    import rx_arb_pkg::*;
#(
    parameter int unsigned C_NUM_CH            = 2,
    parameter int unsigned C_TDATA_WIDTH       = 32,
    parameter int unsigned C_DATA_COUNT_WIDTH  = 11,
    parameter int unsigned C_TOTAL_COUNT_WIDTH = 16,
    parameter int unsigned C_ID_WIDTH          = 3
) (
    input  logic                                    AXIS_ACLK,
    input  logic                                    AXIS_ARESETN,
    input  logic [C_NUM_CH-1:0]                     CH_ENABLE,
    input  logic [C_NUM_CH*C_DATA_COUNT_WIDTH-1:0]  CH_PACKET_COUNT,
    input  logic [C_NUM_CH*C_TDATA_WIDTH-1:0]       S_AXIS_TDATA,
    input  logic [C_NUM_CH-1:0]                     S_AXIS_TVALID,
    input  logic [C_NUM_CH-1:0]                     S_AXIS_TLAST,
    output logic [C_NUM_CH-1:0]                     S_AXIS_TREADY,
    output logic [C_TDATA_WIDTH-1:0]                M_AXIS_TDATA,
    output logic                                    M_AXIS_TVALID,
    output logic                                    M_AXIS_TLAST,
    output logic [C_ID_WIDTH-1:0]                   M_AXIS_TDEST,
    input  logic                                    M_AXIS_TREADY,
    output logic                                    BUSY,
    output logic [C_TOTAL_COUNT_WIDTH-1:0]          TOTAL_GRANT_COUNT
);

    arb_state_t                     state_q, state_d;
    logic [C_ID_WIDTH-1:0]          grant_q, grant_d;
    logic [C_ID_WIDTH-1:0]          last_ch_q, last_ch_d;
    logic [C_TOTAL_COUNT_WIDTH-1:0] total_q, total_d;

    logic [C_NUM_CH-1:0]            eligible;
    logic                           pick_valid;
    logic [C_ID_WIDTH-1:0]          pick_idx;
    logic [C_TDATA_WIDTH-1:0]       sel_data;
    logic                           sel_valid;
    logic                           sel_last;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < C_NUM_CH; i++) begin
            eligible[i] = CH_ENABLE[i] &&
                (CH_PACKET_COUNT[field_lo(i, C_DATA_COUNT_WIDTH) +: C_DATA_COUNT_WIDTH] != '0);
        end
    end

    rr_priority_picker #(
        .C_NUM_CH   (C_NUM_CH),
        .C_ID_WIDTH (C_ID_WIDTH)
    ) u_picker (
        .req   (eligible),
        .last  (last_ch_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int unsigned i = 0; i < C_NUM_CH; i++) begin
            if (grant_q == C_ID_WIDTH'(i)) begin
                sel_data  = S_AXIS_TDATA[field_lo(i, C_TDATA_WIDTH) +: C_TDATA_WIDTH];
                sel_valid = S_AXIS_TVALID[i];
                sel_last  = S_AXIS_TLAST[i];
            end
        end
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            last_ch_q <= C_ID_WIDTH'(C_NUM_CH - 1);
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_ch_q <= last_ch_d;
            total_q   <= total_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_ch_d     = last_ch_q;
        total_d       = total_q;
        M_AXIS_TDATA  = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TDEST  = '0;
        BUSY          = 1'b0;
        S_AXIS_TREADY = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                M_AXIS_TDATA  = sel_data;
                M_AXIS_TVALID = sel_valid;
                M_AXIS_TLAST  = sel_last;
                M_AXIS_TDEST  = grant_q;
                BUSY          = 1'b1;
                for (int unsigned i = 0; i < C_NUM_CH; i++) begin
                    if (grant_q == C_ID_WIDTH'(i)) begin
                        S_AXIS_TREADY[i] = M_AXIS_TREADY;
                    end
                end
                if (sel_valid && M_AXIS_TREADY && sel_last) begin
                    last_ch_d = grant_q;
                    total_d   = total_q + C_TOTAL_COUNT_WIDTH'(1);
                    state_d   = ST_SETTLE;
                end
            end
            // Gives the upstream packet counter a cycle to reflect the drained packet.
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign TOTAL_GRANT_COUNT = total_q;

endmodule

// File: tb/tb_rx_packet_arbiter.sv
// Directed self-checking bench for rx_packet_arbiter (2 channels, default widths).
module tb_rx_packet_arbiter;

    localparam int unsigned NCH = 2;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 11;
    localparam int unsigned TW  = 16;
    localparam int unsigned IW  = 3;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic [NCH-1:0]      ch_enable;
    logic [NCH*CW-1:0]   ch_packet_count;
    logic [NCH*DW-1:0]   s_tdata;
    logic [NCH-1:0]      s_tvalid;
    logic [NCH-1:0]      s_tlast;
    logic [NCH-1:0]      s_tready;
    logic [DW-1:0]       m_tdata;
    logic                m_tvalid;
    logic                m_tlast;
    logic [IW-1:0]       m_tdest;
    logic                m_tready;
    logic                busy;
    logic [TW-1:0]       total;

    int unsigned         n_checks = 0;
    int unsigned         n_fail   = 0;
    logic [TW-1:0]       exp_total;
    int unsigned         cnt [NCH];

    always #5 aclk = ~aclk;

    rx_packet_arbiter #(
        .C_NUM_CH            (NCH),
        .C_TDATA_WIDTH       (DW),
        .C_DATA_COUNT_WIDTH  (CW),
        .C_TOTAL_COUNT_WIDTH (TW),
        .C_ID_WIDTH          (IW)
    ) dut (
        .AXIS_ACLK         (aclk),
        .AXIS_ARESETN      (aresetn),
        .CH_ENABLE         (ch_enable),
        .CH_PACKET_COUNT   (ch_packet_count),
        .S_AXIS_TDATA      (s_tdata),
        .S_AXIS_TVALID     (s_tvalid),
        .S_AXIS_TLAST      (s_tlast),
        .S_AXIS_TREADY     (s_tready),
        .M_AXIS_TDATA      (m_tdata),
        .M_AXIS_TVALID     (m_tvalid),
        .M_AXIS_TLAST      (m_tlast),
        .M_AXIS_TDEST      (m_tdest),
        .M_AXIS_TREADY     (m_tready),
        .BUSY              (busy),
        .TOTAL_GRANT_COUNT (total)
    );

    task automatic expect_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_word(input logic ch, input int unsigned b);
        return {8'hA5, 7'h00, ch, 16'(b)};
    endfunction

    task automatic set_count(input logic ch, input int unsigned val);
        ch_packet_count[ch*CW +: CW] = CW'(val);
        cnt[ch] = val;
    endtask

    task automatic present(input logic ch, input int unsigned b, input logic last);
        s_tdata[ch*DW +: DW] = beat_word(ch, b);
        s_tvalid[ch] = 1'b1;
        s_tlast[ch]  = last;
    endtask

    // Starts at a negedge; returns 1 ns after the negedge of the SETTLE cycle.
    task automatic run_pkt(input logic ch, input int unsigned nbeats, input int unsigned exp_wait);
        int unsigned waited = 0;
        logic [NCH-1:0] exp_rdy = '0;
        exp_rdy[ch] = 1'b1;
        m_tready = 1'b1;
        present(ch, 0, nbeats == 1);
        #1;
        while (!busy && waited < 20) begin
            expect_eq("idle_tvalid", m_tvalid, 0);
            @(negedge aclk);
            #1;
            waited++;
        end
        expect_eq("grant_latency", waited, exp_wait);
        expect_eq("tdest", m_tdest, 64'(ch));
        for (int unsigned b = 0; b < nbeats; b++) begin
            present(ch, b, b == nbeats - 1);
            #1;
            expect_eq("beat_valid", m_tvalid, 1);
            expect_eq("beat_data", m_tdata, beat_word(ch, b));
            expect_eq("beat_last", m_tlast, b == nbeats - 1);
            expect_eq("tready_route", s_tready, exp_rdy);
            @(negedge aclk);
        end
        s_tvalid[ch] = 1'b0;
        s_tlast[ch]  = 1'b0;
        set_count(ch, cnt[ch] - 1);
        exp_total = exp_total + TW'(1);
        #1;
        expect_eq("busy_after_last", busy, 0);
        expect_eq("settle_tvalid", m_tvalid, 0);
        expect_eq("total", total, exp_total);
    endtask

    initial begin
        logic [6:0] pv;
        logic [6:0] pr;
        int unsigned b;

        aresetn         = 1'b0;
        ch_enable       = '0;
        ch_packet_count = '0;
        s_tdata         = '0;
        s_tvalid        = '0;
        s_tlast         = '0;
        m_tready        = 1'b0;
        exp_total       = '0;
        cnt[0]          = 0;
        cnt[1]          = 0;

        repeat (3) @(negedge aclk);
        #1;
        expect_eq("rst_tvalid", m_tvalid, 0);
        expect_eq("rst_tlast", m_tlast, 0);
        expect_eq("rst_tdata", m_tdata, 0);
        expect_eq("rst_tdest", m_tdest, 0);
        expect_eq("rst_busy", busy, 0);
        expect_eq("rst_tready", s_tready, 0);
        expect_eq("rst_total", total, 0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Single channel: 4-beat packet, then a 1-beat packet held off by SETTLE + IDLE.
        ch_enable = 2'b11;
        set_count(0, 1);
        run_pkt(1'b0, 4, 1);
        set_count(0, 1);
        run_pkt(1'b0, 1, 2);

        // Disabled channel with pending packets is never granted.
        ch_enable = 2'b01;
        set_count(1, 2);
        present(1'b1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            #1;
            expect_eq("dis_tvalid", m_tvalid, 0);
            expect_eq("dis_tready", s_tready, 0);
            expect_eq("dis_busy", busy, 0);
        end
        @(negedge aclk);
        ch_enable = 2'b11;
        run_pkt(1'b1, 2, 1);

        // Both channels busy: grants alternate starting at ch0.
        set_count(0, 3);
        set_count(1, 3);
        for (int unsigned i = 0; i < 6; i++) begin
            run_pkt(1'(i % 2), 1 + i % 3, 2);
        end
        expect_eq("alt_counts_drained", ch_packet_count, 0);

        // Back-pressure, upstream stall, enable and count dropping mid-packet.
        set_count(0, 1);
        m_tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        pv = 7'b1111011;
        pr = 7'b1010101;
        b  = 0;
        for (int unsigned k = 0; k < 7; k++) begin
            ch_enable[0] = (k == 0);
            if (k == 2) set_count(0, 0);
            s_tvalid[0] = pv[k];
            m_tready    = pr[k];
            s_tdata[0 +: DW] = beat_word(1'b0, b);
            s_tlast[0]  = (b == 2);
            #1;
            expect_eq("bp_busy", busy, 1);
            expect_eq("bp_tdest", m_tdest, 0);
            expect_eq("bp_valid", m_tvalid, pv[k]);
            expect_eq("bp_data", m_tdata, beat_word(1'b0, b));
            expect_eq("bp_last", m_tlast, pv[k] && b == 2);
            expect_eq("bp_tready", s_tready, {1'b0, pr[k]});
            if (pv[k] && pr[k]) b++;
            @(negedge aclk);
        end
        s_tvalid  = '0;
        s_tlast   = '0;
        ch_enable = 2'b11;
        m_tready  = 1'b1;
        exp_total = exp_total + TW'(1);
        #1;
        expect_eq("bp_beats", b, 3);
        expect_eq("bp_busy_end", busy, 0);
        expect_eq("bp_total", total, exp_total);

        // Total counter wraps.
        force dut.total_q = 16'hFFFF;
        #1;
        release dut.total_q;
        exp_total = 16'hFFFF;
        expect_eq("wrap_preload", total, 16'hFFFF);
        set_count(1, 1);
        run_pkt(1'b1, 3, 2);
        expect_eq("wrap_zero", total, 0);

        // Asynchronous reset mid-packet.
        set_count(0, 1);
        set_count(1, 1);
        present(1'b0, 0, 1'b0);
        m_tready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        #1;
        expect_eq("pre_rst_busy", busy, 1);
        expect_eq("pre_rst_tdest", m_tdest, 0);
        @(negedge aclk);
        present(1'b0, 1, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        exp_total = '0;
        expect_eq("arst_tvalid", m_tvalid, 0);
        expect_eq("arst_busy", busy, 0);
        expect_eq("arst_tready", s_tready, 0);
        expect_eq("arst_tdata", m_tdata, 0);
        expect_eq("arst_total", total, 0);
        @(negedge aclk);
        @(negedge aclk);
        s_tvalid = '0;
        aresetn  = 1'b1;
        run_pkt(1'b0, 2, 1);
        run_pkt(1'b1, 1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
